// File: rtl/sram_mac_result_accumulator_pkg.sv
// Shared definitions for the MAC result accumulator and the sequencers that
// drive it: FSM state encoding, default widths and the MAC-block op codes.
package sram_mac_result_accumulator_pkg;

    // Default accumulator and per-tile sum widths
    localparam int ACC_W_DEF     = 24;
    localparam int SUM_W_DEF     = 19;

    // The MAC block serializes each dot product as this many bytes, MS first
    localparam int NUM_SUM_BYTES = 3;

    // Op encodings understood by the 8-lane MAC/adder-tree block.
    // in_start is pulsed on the edge the MAC block samples MAC_READ_S.
    typedef enum logic [1:0] {
        MAC_NOP    = 2'b00,
        MAC_LOAD_W = 2'b01,
        MAC_LOAD_A = 2'b10,
        MAC_READ_S = 2'b11
    } mac_op_e;

    // Accumulator sequencing states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CAP2  = 3'd2,
        S_CAP1  = 3'd3,
        S_CAP0  = 3'd4,
        S_ACCUM = 3'd5,
        S_EMIT  = 3'd6
    } acc_state_e;

endpackage

// File: rtl/sram_mac_result_accumulator_requant.sv
// Requantizer: rounds an accumulator value half-up at the given right-shift
// and saturates the result to an unsigned byte. Purely combinational.
module requant_sat
    import sram_mac_result_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    output logic [7:0]       q_sat
);

    // One extra bit holds the rounding carry. A rounding constant wider than
    // ACC_W+1 bits shifts out to zero, which is harmless: the shifted result
    // is zero in that case anyway.
    logic [ACC_W:0] rnd;
    logic [ACC_W:0] t;
    logic [ACC_W:0] q;

    // Add half an LSB of the output scale, shift, then clamp to 0..255
    always_comb begin
        rnd = '0;
        if (shift != 5'd0)
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
        t     = {1'b0, acc} + rnd;
        q     = t >> shift;
        q_sat = (|q[ACC_W:8]) ? 8'hFF : q[7:0];
    end

endmodule

// File: rtl/sram_mac_result_accumulator.sv
// Captures the MAC block's serialized 3-byte dot-product stream, accumulates
// the per-tile sums across tiles, and on the last tile publishes a rounded,
// saturated 8-bit result through a valid/ready output register.
module sram_mac_result_accumulator
    import sram_mac_result_accumulator_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SUM_W   = SUM_W_DEF,
    parameter int CAP_DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_start,
    input  logic             in_clear,
    input  logic             in_last,
    input  logic [4:0]       in_shift,
    input  logic [7:0]       in_byte,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [ACC_W-1:0] out_raw,
    output logic             busy,
    output logic             acc_ovf,
    output logic             err_busy,
    output logic             err_overrun
);

    // Wait counter holds "cycles left minus one"; sized for at least one bit
    localparam int CNT_W = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = (CAP_DLY > 0) ? CNT_W'(CAP_DLY - 1) : '0;

    // Only the low SUM_W-16 bits of the MS byte carry sum information
    localparam int HI_W = SUM_W - 16;

    acc_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             clear_q;
    logic             last_q;
    logic [4:0]       shift_q;
    logic [HI_W-1:0]  cap_hi;
    logic [7:0]       cap_mid;
    logic [7:0]       cap_lo;
    logic [ACC_W-1:0] acc;

    logic [SUM_W-1:0] sum;
    logic [ACC_W:0]   acc_sum;
    logic [7:0]       q_sat;
    logic             emit;
    logic             ovf_evt;
    logic             busy_evt;
    logic             overrun_evt;

    // Bits of the MS byte above the sum width are deliberately dropped
    logic             unused_byte_bits;
    assign unused_byte_bits = ^in_byte[7:HI_W];

    assign sum     = {cap_hi, cap_mid, cap_lo};
    assign acc_sum = {1'b0, (clear_q ? {ACC_W{1'b0}} : acc)}
                   + {{(ACC_W + 1 - SUM_W){1'b0}}, sum};

    assign emit        = (state == S_EMIT);
    assign ovf_evt     = (state == S_ACCUM) && acc_sum[ACC_W];
    assign busy_evt    = in_start && (state != S_IDLE);
    assign overrun_evt = emit && out_valid && !out_ready;
    assign busy        = (state != S_IDLE);

    requant_sat #(.ACC_W(ACC_W)) u_requant (
        .acc   (acc),
        .shift (shift_q),
        .q_sat (q_sat)
    );

    // Sequencer: accept a tile, sample the free-running byte stream on fixed
    // edges, then fold the tile sum into the saturating accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            clear_q  <= 1'b0;
            last_q   <= 1'b0;
            shift_q  <= '0;
            cap_hi   <= '0;
            cap_mid  <= '0;
            cap_lo   <= '0;
            acc      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_start) begin
                        clear_q <= in_clear;
                        last_q  <= in_last;
                        shift_q <= in_shift;
                        if (CAP_DLY == 0) begin
                            state <= S_CAP2;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0)
                        state <= S_CAP2;
                    else
                        wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_CAP2: begin
                    cap_hi <= in_byte[HI_W-1:0];
                    state  <= S_CAP1;
                end
                S_CAP1: begin
                    cap_mid <= in_byte;
                    state   <= S_CAP0;
                end
                S_CAP0: begin
                    cap_lo <= in_byte;
                    state  <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc   <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
                    state <= last_q ? S_EMIT : S_IDLE;
                end
                S_EMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: a new result loads only if the slot is free or being
    // drained this cycle; otherwise the held result is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_raw   <= '0;
        end else if (emit && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= q_sat;
            out_raw   <= acc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags: a set event in the same cycle beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_ovf     <= 1'b0;
            err_busy    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            acc_ovf     <= (acc_ovf     & ~err_clr) | ovf_evt;
            err_busy    <= (err_busy    & ~err_clr) | busy_evt;
            err_overrun <= (err_overrun & ~err_clr) | overrun_evt;
        end
    end

endmodule

// File: tb/tb_sram_mac_result_accumulator.sv
// Directed bench for the MAC result accumulator: a table of single-tile
// vectors plus hand-written multi-tile, overrun, busy/reset and overflow cases.
module tb_sram_mac_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start, in_clear, in_last;
    logic [4:0]  in_shift;
    logic [7:0]  in_byte;
    logic        err_clr;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [23:0] out_raw;
    logic        busy, acc_ovf, err_busy, err_overrun;

    int n_chk  = 0;
    int n_fail = 0;
    logic vld_n5, busy_n5;

    typedef struct {
        logic [4:0]  shift;
        logic [7:0]  b2, b1, b0;
        logic [23:0] exp_raw;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[10];

    sram_mac_result_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .in_start    (in_start),
        .in_clear    (in_clear),
        .in_last     (in_last),
        .in_shift    (in_shift),
        .in_byte     (in_byte),
        .err_clr     (err_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_raw     (out_raw),
        .busy        (busy),
        .acc_ovf     (acc_ovf),
        .err_busy    (err_busy),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One tile: start sampled at edge N, bytes presented for edges N+2..N+4.
    // Returns at the negedge after N+6; state seen after N+5 is recorded.
    task automatic run_tile(input logic clr, input logic lst, input logic [4:0] sh,
                            input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0,
                            input logic rdy_emit);
        @(negedge clk);
        in_start = 1'b1; in_clear = clr; in_last = lst; in_shift = sh;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0; in_clear = 1'b0; in_last = 1'b0; in_shift = 5'd0;
        @(posedge clk);
        @(negedge clk); in_byte = b2;
        @(posedge clk);
        @(negedge clk); in_byte = b1;
        @(posedge clk);
        @(negedge clk); in_byte = b0;
        @(posedge clk);
        @(negedge clk); in_byte = 8'h00;
        @(posedge clk);
        @(negedge clk);
        vld_n5  = out_valid;
        busy_n5 = busy;
        if (rdy_emit) out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("consume_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            shift   b2     b1     b0     raw          data
        vecs[0] = '{5'd12, 8'h01, 8'h23, 8'h45, 24'h012345, 8'h12};
        vecs[1] = '{5'd0,  8'h01, 8'h23, 8'h45, 24'h012345, 8'hFF};
        vecs[2] = '{5'd4,  8'hF8, 8'h00, 8'h18, 24'h000018, 8'h02};
        vecs[3] = '{5'd4,  8'h00, 8'h00, 8'h17, 24'h000017, 8'h01};
        vecs[4] = '{5'd0,  8'h00, 8'h00, 8'hFF, 24'h0000FF, 8'hFF};
        vecs[5] = '{5'd4,  8'h00, 8'h0F, 8'hF8, 24'h000FF8, 8'hFF};
        vecs[6] = '{5'd4,  8'h00, 8'h0F, 8'hF7, 24'h000FF7, 8'hFF};
        vecs[7] = '{5'd31, 8'h07, 8'hFF, 8'hFF, 24'h07FFFF, 8'h00};
        vecs[8] = '{5'd1,  8'h00, 8'h00, 8'h03, 24'h000003, 8'h02};
        vecs[9] = '{5'd12, 8'h07, 8'hFF, 8'hFF, 24'h07FFFF, 8'h80};

        rst = 1'b1; in_start = 1'b0; in_clear = 1'b0; in_last = 1'b0;
        in_shift = 5'd0; in_byte = 8'h00; err_clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_data",    {24'd0, out_data},  32'd0);
        check("rst_raw",     {8'd0, out_raw},    32'd0);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_flags",   {29'd0, acc_ovf, err_busy, err_overrun}, 32'd0);
        rst = 1'b0;

        // Single-tile vectors with clear+last; latency, value and drain each
        for (int i = 0; i < 10; i++) begin
            run_tile(1'b1, 1'b1, vecs[i].shift, vecs[i].b2, vecs[i].b1, vecs[i].b0, 1'b0);
            check($sformatf("v%0d_valid_n5", i), {31'd0, vld_n5},    32'd0);
            check($sformatf("v%0d_busy_n5", i),  {31'd0, busy_n5},   32'd1);
            check($sformatf("v%0d_valid_n6", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_busy_n6", i),  {31'd0, busy},      32'd0);
            check($sformatf("v%0d_data", i),     {24'd0, out_data},  {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d_raw", i),      {8'd0, out_raw},    {8'd0, vecs[i].exp_raw});
            consume();
        end

        // Two tiles: no output after the first, combined sum after the second
        run_tile(1'b1, 1'b0, 5'd0, 8'h00, 8'h01, 8'h00, 1'b0);
        check("t3_no_out", {31'd0, out_valid}, 32'd0);
        run_tile(1'b0, 1'b1, 5'd4, 8'h00, 8'h01, 8'h80, 1'b0);
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        check("t3_raw",   {8'd0, out_raw},    32'h280);
        check("t3_data",  {24'd0, out_data},  32'h28);

        // Result held, consumer stalled: new result dropped, overrun flagged
        run_tile(1'b1, 1'b1, 5'd0, 8'h00, 8'h00, 8'h05, 1'b0);
        check("t4_data",    {24'd0, out_data},    32'h28);
        check("t4_raw",     {8'd0, out_raw},      32'h280);
        check("t4_overrun", {31'd0, err_overrun}, 32'd1);
        pulse_err_clr();
        check("t4_clr", {31'd0, err_overrun}, 32'd0);

        // Start while busy is ignored and flagged; reset mid-capture
        @(negedge clk);
        in_start = 1'b1; in_clear = 1'b1; in_last = 1'b1; in_shift = 5'd0;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0; in_clear = 1'b0; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b1; in_byte = 8'h07;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0; in_byte = 8'h00;
        check("t5_err_busy", {31'd0, err_busy},  32'd1);
        check("t5_busy",     {31'd0, busy},      32'd1);
        check("t5_held",     {24'd0, out_data},  32'h28);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_busy",  {31'd0, busy},      32'd0);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_data",  {24'd0, out_data},  32'd0);
        check("t5_rst_raw",   {8'd0, out_raw},    32'd0);
        check("t5_rst_flags", {29'd0, acc_ovf, err_busy, err_overrun}, 32'd0);
        @(negedge clk); rst = 1'b0;
        // No clear: relies on the accumulator having been reset to zero
        run_tile(1'b0, 1'b1, 5'd4, 8'h00, 8'h01, 8'h00, 1'b0);
        check("t5_clean_raw",  {8'd0, out_raw},   32'h100);
        check("t5_clean_data", {24'd0, out_data}, 32'h10);

        // Held result replaced without loss when drained during EMIT
        run_tile(1'b1, 1'b1, 5'd4, 8'h00, 8'h00, 8'h30, 1'b1);
        check("rep_valid",   {31'd0, out_valid},   32'd1);
        check("rep_data",    {24'd0, out_data},    32'h03);
        check("rep_overrun", {31'd0, err_overrun}, 32'd0);
        consume();

        // 33 full-scale tiles saturate the accumulator on the last one
        for (int i = 0; i < 33; i++) begin
            run_tile(i == 0, i == 32, 5'd16, 8'h07, 8'hF0, 8'h08, 1'b0);
            if (i == 31) check("t6_no_ovf_yet", {31'd0, acc_ovf}, 32'd0);
        end
        check("t6_valid", {31'd0, out_valid}, 32'd1);
        check("t6_raw",   {8'd0, out_raw},    32'hFFFFFF);
        check("t6_data",  {24'd0, out_data},  32'hFF);
        check("t6_ovf",   {31'd0, acc_ovf},   32'd1);
        pulse_err_clr();
        check("t6_ovf_clr", {31'd0, acc_ovf}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
